// File: rtl/uart_fifo_pkg.sv
// uart_fifo_pkg: register map, control bit positions and TX drain FSM states.
// Rev 1.0
`default_nettype none

package uart_fifo_pkg;

   localparam logic [1:0] UART_RX   = 2'b00;
   localparam logic [1:0] UART_RXCR = 2'b01;
   localparam logic [1:0] UART_TX   = 2'b10;
   localparam logic [1:0] UART_TXCR = 2'b11;

   localparam int FLUSH_BIT    = 7;
   localparam int CLEAR_BIT    = 6;
   localparam int LOOPBACK_BIT = 5;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_HOLD  = 2'd2
   } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/async_receiver.sv
// async_receiver: oversampling 8N1 serial receiver with input synchroniser.
// Rev 1.0
`default_nettype none

module async_receiver #(
   parameter int ClkFrequency = 25000000,
   parameter int Baud         = 115200,
   parameter int Oversampling = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic       rx_data_ready,
   output logic [7:0] rx_data,
   output logic       rx_idle
);

   localparam int TICK_CLKS = ClkFrequency / (Baud * Oversampling);
   localparam int TW        = $clog2(TICK_CLKS + 1);
   localparam int OW        = $clog2(Oversampling);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CLKS - 1);
   localparam logic [TW-1:0] TICK_ONE  = TW'(1);
   localparam logic [OW-1:0] OS_MID    = OW'(Oversampling / 2 - 1);
   localparam logic [OW-1:0] OS_LAST   = OW'(Oversampling - 1);
   localparam logic [OW-1:0] OS_ONE    = OW'(1);

   logic [1:0]    sync;
   logic [TW-1:0] tick_cnt;
   logic          tick;
   logic          busy;
   logic [OW-1:0] os_cnt;
   logic [3:0]    bit_cnt;

   assign tick    = (tick_cnt == TICK_LAST);
   assign rx_idle = !busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync          <= 2'b11;
         tick_cnt      <= '0;
         busy          <= 1'b0;
         os_cnt        <= '0;
         bit_cnt       <= '0;
         rx_data       <= '0;
         rx_data_ready <= 1'b0;
      end else begin
         sync          <= {sync[0], rxd};
         tick_cnt      <= tick ? '0 : tick_cnt + TICK_ONE;
         rx_data_ready <= 1'b0;
         if (tick) begin
            if (!busy) begin
               if (!sync[1]) begin
                  busy    <= 1'b1;
                  os_cnt  <= '0;
                  bit_cnt <= '0;
               end
            end else begin
               os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_ONE;
               if (os_cnt == OS_MID) begin
                  bit_cnt <= bit_cnt + 4'd1;
                  // A start bit that is high again at mid-bit was a glitch.
                  if (bit_cnt == 4'd0) begin
                     if (sync[1]) busy <= 1'b0;
                  end else if (bit_cnt == 4'd9) begin
                     busy          <= 1'b0;
                     rx_data_ready <= sync[1];
                  end else begin
                     rx_data <= {sync[1], rx_data[7:1]};
                  end
               end
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/async_transmitter.sv
// async_transmitter: 8N1 serial transmitter, one start, eight data, one stop bit.
// Rev 1.0
`default_nettype none

module async_transmitter #(
   parameter int ClkFrequency = 25000000,
   parameter int Baud         = 115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       txd,
   output logic       tx_busy
);

   localparam int BIT_CLKS = ClkFrequency / Baud;
   localparam int BW       = $clog2(BIT_CLKS + 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(BIT_CLKS - 1);
   localparam logic [BW-1:0] CNT_ONE  = BW'(1);

   logic [BW-1:0] baud_cnt;
   logic [3:0]    bit_cnt;
   logic [8:0]    shreg;

   always_ff @(posedge clk) begin
      if (rst) begin
         txd      <= 1'b1;
         tx_busy  <= 1'b0;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '1;
      end else if (!tx_busy) begin
         if (tx_start) begin
            tx_busy  <= 1'b1;
            txd      <= 1'b0;
            shreg    <= {1'b1, tx_data};
            baud_cnt <= '0;
            bit_cnt  <= '0;
         end
      end else if (baud_cnt == BIT_LAST) begin
         baud_cnt <= '0;
         // Busy stays up through the whole stop bit.
         if (bit_cnt == 4'd9) begin
            tx_busy <= 1'b0;
         end else begin
            bit_cnt <= bit_cnt + 4'd1;
            txd     <= shreg[0];
            shreg   <= {1'b1, shreg[8:1]};
         end
      end else begin
         baud_cnt <= baud_cnt + CNT_ONE;
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: synchronous FIFO with flush, full/empty flags and fill level.
// Rev 1.0
`default_nettype none

module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic                    pop,
   input  logic                    flush,
   input  logic [WIDTH-1:0]        din,
   output logic [WIDTH-1:0]        head,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level = wr_ptr - rd_ptr;
   assign head  = mem[rd_ptr[AW-1:0]];

   // A pop frees the slot being written, so a full FIFO may still accept a push.
   assign do_pop  = pop && !empty && !flush;
   assign do_push = push && (!full || do_pop) && !flush;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

`default_nettype wire

// File: rtl/uart_fifo.sv
// uart_fifo: Apple-1 PIA-style serial console with RX/TX FIFOs, sticky overruns and CTS.
// Rev 1.0 -- optional loopback enabled by defining UART_FIFO_LOOPBACK_EN.
`default_nettype none

module uart_fifo
   import uart_fifo_pkg::*;
#(
   parameter int ClkFrequency = 25000000,
   parameter int Baud         = 115200,
   parameter int Oversampling = 16,
   parameter int RxDepth      = 16,
   parameter int TxDepth      = 16,
   parameter int CtsMargin    = 4,
   parameter int SkipFirstTx  = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [1:0] address,
   input  logic       w_en,
   input  logic [7:0] din,
   output logic [7:0] dout,
   input  logic       uart_rx,
   output logic       uart_tx,
   output logic       uart_cts
);

   localparam int RAW = $clog2(RxDepth);
   localparam logic [RAW:0] CTS_LEVEL = (RAW+1)'(RxDepth - CtsMargin);

   logic rd_acc, wr_acc, flush, clear;
   logic rx_pop, rx_full, rx_empty;
   logic [RAW:0] rx_level;
   logic [7:0] rx_head, rx_data, last_rx;
   logic rx_data_ready, rx_idle, rx_overrun;
   logic tx_push, tx_pop, tx_full, tx_empty, tx_ovf;
   logic [$clog2(TxDepth):0] tx_level;
   logic [7:0] tx_head, tx_data;
   logic tx_start, tx_busy, txd, rx_in, loopback, skip_armed;
   tx_state_t tx_state;

   assign rd_acc  = enable && !w_en;
   assign wr_acc  = enable && w_en;
   assign flush   = wr_acc && (address == UART_TXCR) && din[FLUSH_BIT];
   assign clear   = wr_acc && (address == UART_TXCR) && din[CLEAR_BIT];
   assign rx_pop  = rd_acc && (address == UART_RX);
   assign tx_push = wr_acc && (address == UART_TX) && !skip_armed;
   assign tx_pop  = (tx_state == TX_IDLE) && (tx_level != '0) && !tx_busy && !flush;

   assign uart_cts = !rx_idle || (rx_level >= CTS_LEVEL);

   uart_sync_fifo #(.WIDTH(8), .DEPTH(RxDepth)) u_rx_fifo (
      .clk(clk), .rst(rst), .push(rx_data_ready), .pop(rx_pop), .flush(flush),
      .din(rx_data), .head(rx_head), .full(rx_full), .empty(rx_empty), .level(rx_level)
   );

   uart_sync_fifo #(.WIDTH(8), .DEPTH(TxDepth)) u_tx_fifo (
      .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .flush(flush),
      .din({1'b0, din[6:0]}), .head(tx_head), .full(tx_full), .empty(tx_empty), .level(tx_level)
   );

   async_transmitter #(.ClkFrequency(ClkFrequency), .Baud(Baud)) u_tx (
      .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data), .txd(txd), .tx_busy(tx_busy)
   );

   async_receiver #(.ClkFrequency(ClkFrequency), .Baud(Baud), .Oversampling(Oversampling)) u_rx (
      .clk(clk), .rst(rst), .rxd(rx_in), .rx_data_ready(rx_data_ready), .rx_data(rx_data), .rx_idle(rx_idle)
   );

`ifdef UART_FIFO_LOOPBACK_EN
   always_ff @(posedge clk) begin
      if (rst)                                   loopback <= 1'b0;
      else if (wr_acc && address == UART_TXCR)   loopback <= din[LOOPBACK_BIT];
   end
   assign rx_in   = loopback ? txd : uart_rx;
   assign uart_tx = loopback ? 1'b1 : txd;
`else
   assign loopback = 1'b0;
   assign rx_in    = uart_rx;
   assign uart_tx  = txd;
`endif

   // Sticky flags; a set in the same cycle as a clear takes precedence.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_overrun <= 1'b0;
         tx_ovf     <= 1'b0;
         skip_armed <= (SkipFirstTx != 0);
         last_rx    <= '0;
      end else begin
         if (clear) begin
            rx_overrun <= 1'b0;
            tx_ovf     <= 1'b0;
         end
         if (rx_data_ready && rx_full && !rx_pop && !flush) rx_overrun <= 1'b1;
         if (tx_push && tx_full && !tx_pop && !flush)       tx_ovf     <= 1'b1;
         if (wr_acc && address == UART_TX)                  skip_armed <= 1'b0;
         if (rx_pop && !rx_empty && !flush)                 last_rx    <= rx_head;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dout <= '0;
      end else begin
         case (address)
            UART_RX:   dout <= (rx_empty ? last_rx : rx_head) | 8'h80;
            UART_RXCR: dout <= {!rx_empty, rx_overrun, 6'b0};
            UART_TX:   dout <= {tx_full, 7'b0};
            default: begin
               dout               <= {tx_empty, tx_ovf, 6'b0};
               dout[LOOPBACK_BIT] <= loopback;
            end
         endcase
      end
   end

   // START exists so busy, which rises a cycle after tx_start, is seen by HOLD.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state <= TX_IDLE;
         tx_start <= 1'b0;
         tx_data  <= '0;
      end else begin
         case (tx_state)
            TX_IDLE: begin
               if (tx_pop) begin
                  tx_data  <= tx_head;
                  tx_start <= 1'b1;
                  tx_state <= TX_START;
               end
            end
            TX_START: begin
               tx_start <= 1'b0;
               tx_state <= TX_HOLD;
            end
            TX_HOLD: begin
               if (!tx_busy) tx_state <= TX_IDLE;
            end
            default: begin
               tx_start <= 1'b0;
               tx_state <= TX_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: directed scoreboard bench for uart_fifo (serial host model plus line monitor).
// Rev 1.0
`default_nettype none

module tb_uart_fifo;

   localparam int BIT      = 32;
   localparam int RX_DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst, enable, w_en, uart_rx;
   logic [1:0] address;
   logic [7:0] din;
   logic [7:0] dout;
   logic       uart_tx, uart_cts;

   int tests = 0;
   int fails = 0;

   logic [7:0] tx_exp[$];
   logic [7:0] rx_exp[$];
   logic [7:0] last_exp = 8'h80;
   logic       burst    = 1'b0;
   logic       have_prev = 1'b0;

   uart_fifo #(
      .ClkFrequency(3200000), .Baud(100000), .Oversampling(16),
      .RxDepth(RX_DEPTH), .TxDepth(16), .CtsMargin(4), .SkipFirstTx(1)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .address(address), .w_en(w_en),
      .din(din), .dout(dout), .uart_rx(uart_rx), .uart_tx(uart_tx), .uart_cts(uart_cts)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   task automatic reg_write(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      address = a; din = d; w_en = 1'b1; enable = 1'b1;
      @(negedge clk);
      w_en = 1'b0; enable = 1'b0;
   endtask

   task automatic reg_read(input logic [1:0] a, output logic [7:0] d);
      @(negedge clk);
      address = a; w_en = 1'b0; enable = 1'b1;
      @(posedge clk);
      #1 d = dout;
      @(negedge clk);
      enable = 1'b0;
   endtask

   task automatic check_reg(input string tag, input logic [1:0] a, input logic [7:0] exp);
      logic [7:0] d;
      reg_read(a, d);
      check(tag, d, exp);
   endtask

   task automatic read_rx(input string tag);
      logic [7:0] d;
      logic [7:0] exp;
      exp = (rx_exp.size() != 0) ? rx_exp.pop_front() : last_exp;
      last_exp = exp;
      reg_read(2'b00, d);
      check(tag, d, exp);
   endtask

   task automatic host_send(input logic [7:0] b);
      logic [9:0] frame;
      frame = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         uart_rx = frame[i];
         repeat (BIT - 1) @(negedge clk);
      end
      if (rx_exp.size() < RX_DEPTH) rx_exp.push_back(b | 8'h80);
   endtask

   task automatic wait_tx_done(input string tag, input int bound);
      int n = 0;
      while (tx_exp.size() != 0 && n < bound) begin
         @(negedge clk);
         n++;
      end
      tests++;
      assert (tx_exp.size() == 0) else begin
         fails++;
         $error("FAIL %s: observed %0d frames outstanding expected 0", tag, tx_exp.size());
      end
   endtask

   // Line monitor: decodes uart_tx and scores each frame against tx_exp.
   initial begin
      int gap = 0;
      logic [7:0] b;
      logic [7:0] exp;
      forever begin
         @(negedge clk);
         if (uart_tx === 1'b0) begin
            if (burst && have_prev) check("tx_gap_le_48clk", 8'(gap <= BIT + BIT / 2), 8'h01);
            repeat (BIT / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (BIT) @(negedge clk);
               b[i] = uart_tx;
            end
            repeat (BIT) @(negedge clk);
            check("tx_stop_bit", {7'b0, uart_tx}, 8'h01);
            tests++;
            assert (tx_exp.size() != 0) else begin
               fails++;
               $error("FAIL tx_unexpected: observed %02h expected no frame", b);
            end
            if (tx_exp.size() != 0) begin
               exp = tx_exp.pop_front();
               check("tx_byte", b, exp);
            end
            gap = 0;
            have_prev = 1'b1;
         end else begin
            gap++;
         end
      end
   end

   initial begin
      repeat (80000) @(posedge clk);
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic stay_high;
      rst = 1'b1; enable = 1'b0; w_en = 1'b0; address = 2'b00; din = '0; uart_rx = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_dout", dout, 8'h00);
      check("rst_uart_tx", {7'b0, uart_tx}, 8'h01);
      check("rst_cts", {7'b0, uart_cts}, 8'h00);
      @(negedge clk) rst = 1'b0;

      check_reg("rst_txcr", 2'b11, 8'h80);
      check_reg("rst_rxcr", 2'b01, 8'h00);
      check_reg("rst_tx_status", 2'b10, 8'h00);
      read_rx("rst_rx_empty_read");

      // First TX write after reset is swallowed; bit 7 of the data is stripped.
      reg_write(2'b10, 8'h8D);
      reg_write(2'b10, 8'hC1);
      tx_exp.push_back(8'h41);
      wait_tx_done("tx_first_frame", 2000);
      check_reg("txcr_empty_again", 2'b11, 8'h80);

      host_send(8'h31); host_send(8'h32); host_send(8'h33);
      check_reg("rxcr_avail", 2'b01, 8'h80);
      for (int i = 0; i < 3; i++) read_rx("rx_byte");
      check_reg("rxcr_drained", 2'b01, 8'h00);
      read_rx("rx_empty_last_value");

      // CTS threshold is 16-4 = 12 entries.
      for (int i = 0; i < 11; i++) host_send(8'h40 + 8'(i));
      check("cts_below_level", {7'b0, uart_cts}, 8'h00);
      host_send(8'h4B);
      check("cts_at_level", {7'b0, uart_cts}, 8'h01);
      read_rx("rx_cts_read");
      check("cts_after_read", {7'b0, uart_cts}, 8'h00);
      for (int i = 0; i < 6; i++) host_send(8'h4C + 8'(i));
      check_reg("rxcr_overrun", 2'b01, 8'hC0);
      for (int i = 0; i < 16; i++) read_rx("rx_full_readback");
      check_reg("rxcr_overrun_sticky", 2'b01, 8'h40);
      reg_write(2'b11, 8'h40);
      check_reg("rxcr_cleared", 2'b01, 8'h00);

      host_send(8'h61); host_send(8'h62);
      reg_write(2'b11, 8'h80);
      rx_exp.delete();
      check_reg("rxcr_after_flush", 2'b01, 8'h00);

      // Flush leaves the byte already in the transmitter alone.
      reg_write(2'b10, 8'h11);
      tx_exp.push_back(8'h11);
      reg_write(2'b10, 8'h22);
      reg_write(2'b10, 8'h33);
      reg_write(2'b11, 8'h80);
      check_reg("txcr_after_flush", 2'b11, 8'h80);
      wait_tx_done("tx_flush_frame", 2000);
      repeat (700) @(negedge clk);

      // One byte leaves for the transmitter at once, 16 fill the FIFO, the 18th overflows.
      have_prev = 1'b0;
      burst = 1'b1;
      for (int i = 0; i < 18; i++) begin
         reg_write(2'b10, 8'h60 + 8'(i));
         if (i < 17) tx_exp.push_back(8'h60 + 8'(i));
      end
      check_reg("tx_full_status", 2'b10, 8'h80);
      check_reg("txcr_ovf", 2'b11, 8'h40);
      wait_tx_done("tx_burst", 8000);
      burst = 1'b0;
      check_reg("txcr_ovf_sticky", 2'b11, 8'hC0);
      reg_write(2'b11, 8'h40);
      check_reg("txcr_ovf_cleared", 2'b11, 8'h80);

`ifdef UART_FIFO_LOOPBACK_EN
      reg_write(2'b11, 8'h20);
      check_reg("txcr_loopback", 2'b11, 8'hA0);
      reg_write(2'b10, 8'h55);
      stay_high = 1'b1;
      repeat (400) begin
         @(negedge clk);
         if (uart_tx !== 1'b1) stay_high = 1'b0;
      end
      check("lb_uart_tx_idle", {7'b0, stay_high}, 8'h01);
      rx_exp.push_back(8'hD5);
      read_rx("lb_rx_byte");
      reg_write(2'b11, 8'h00);
      check_reg("txcr_loopback_off", 2'b11, 8'h80);
`else
      stay_high = 1'b1;
      check("uart_tx_idle", {7'b0, uart_tx}, {7'b0, stay_high});
`endif

      repeat (10) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
